// File: rtl/mux2x1_arbiter_pkg.sv
// Shared types and constants for the two-requester round-robin mux arbiter.
package mux2x1_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT1 = 2'd1,
    GRANT2 = 2'd2
  } state_t;

  localparam logic SEL_IN1 = 1'b0;
  localparam logic SEL_IN2 = 1'b1;

  localparam int CNT_W = 8;

endpackage

// File: rtl/mux2x1_rtl_2.sv
// One-bit 2:1 multiplexer; sel=0 passes a, sel=1 passes b.
module mux2x1_rtl_2 (
  input  logic a,
  input  logic b,
  input  logic sel,
  output logic y
);

  assign y = sel ? b : a;

endmodule

// File: rtl/mux2x1_arbiter.sv
// Round-robin burst arbiter sharing one 2:1 data mux between two valid/ready
// requesters, followed by a one-entry registered output stage.
module mux2x1_arbiter
  import mux2x1_arbiter_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int BURST_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in1_valid,
  input  logic [DATA_W-1:0] in1_data,
  output logic              in1_ready,
  input  logic              in2_valid,
  input  logic [DATA_W-1:0] in2_data,
  output logic              in2_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              select,
  output logic              busy
);

  state_t             state;
  logic               last;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W:0]     cnt_inc;
  logic               burst_done;
  logic               xfer;
  logic               can_take;
  logic [DATA_W-1:0]  mux_y;

  // Once the burst length is reached with nobody waiting, the count parks at
  // BURST_MAX so the very next beat after the other side shows up hands over.
  function automatic logic [CNT_W-1:0] sat_cnt(input logic [CNT_W:0] inc,
                                                input logic          done);
    return done ? CNT_W'(BURST_MAX) : inc[CNT_W-1:0];
  endfunction

  always_comb begin
    can_take   = !out_valid || out_ready;
    in1_ready  = (state == GRANT1) && can_take;
    in2_ready  = (state == GRANT2) && can_take;
    xfer       = (in1_valid && in1_ready) || (in2_valid && in2_ready);
    cnt_inc    = {1'b0, cnt} + {{CNT_W{1'b0}}, 1'b1};
    burst_done = cnt_inc >= (CNT_W+1)'(BURST_MAX);
  end

  for (genvar i = 0; i < DATA_W; i++) begin : g_mux
    mux2x1_rtl_2 u_mux (
      .a   (in1_data[i]),
      .b   (in2_data[i]),
      .sel (select),
      .y   (mux_y[i])
    );
  end

  // Grant FSM: state, select, busy, last and burst count all registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      select <= SEL_IN1;
      busy   <= 1'b0;
      last   <= SEL_IN2;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in1_valid && (!in2_valid || last == SEL_IN2)) begin
            state  <= GRANT1;
            select <= SEL_IN1;
            last   <= SEL_IN1;
            busy   <= 1'b1;
            cnt    <= '0;
          end else if (in2_valid) begin
            state  <= GRANT2;
            select <= SEL_IN2;
            last   <= SEL_IN2;
            busy   <= 1'b1;
            cnt    <= '0;
          end
        end
        GRANT1: begin
          if (!in1_valid || (xfer && burst_done && in2_valid)) begin
            cnt <= '0;
            if (in2_valid) begin
              state  <= GRANT2;
              select <= SEL_IN2;
              last   <= SEL_IN2;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else if (xfer) begin
            cnt <= sat_cnt(cnt_inc, burst_done);
          end
        end
        GRANT2: begin
          if (!in2_valid || (xfer && burst_done && in1_valid)) begin
            cnt <= '0;
            if (in1_valid) begin
              state  <= GRANT1;
              select <= SEL_IN1;
              last   <= SEL_IN1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else if (xfer) begin
            cnt <= sat_cnt(cnt_inc, burst_done);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Output stage: one registered beat, refilled in the same cycle it drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= mux_y;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux2x1_arbiter.sv
// Bench for mux2x1_arbiter: directed scenarios with literal expectations plus
// a randomized run compared every cycle against a behavioural model.
module tb_mux2x1_arbiter;
  localparam int DATA_W    = 8;
  localparam int BURST_MAX = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in1_valid, in2_valid, out_ready;
  logic [DATA_W-1:0] in1_data, in2_data;
  logic              in1_ready, in2_ready, out_valid, select, busy;
  logic [DATA_W-1:0] out_data;

  always #5 clk = ~clk;

  mux2x1_arbiter #(.DATA_W(DATA_W), .BURST_MAX(BURST_MAX)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in1_valid (in1_valid),
    .in1_data  (in1_data),
    .in1_ready (in1_ready),
    .in2_valid (in2_valid),
    .in2_data  (in2_data),
    .in2_ready (in2_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .select    (select),
    .busy      (busy)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Behavioural model: who owns the mux, beats served in this grant,
  // who was served last, and the contents of the output slot.
  int         m_owner;
  int         m_beats;
  int         m_last;
  logic       m_sel;
  logic       m_ov;
  logic [7:0] m_od;

  function automatic logic vof(input int n);
    return (n == 1) ? in1_valid : in2_valid;
  endfunction

  function automatic logic [7:0] dof(input int n);
    return (n == 1) ? in1_data : in2_data;
  endfunction

  task automatic give(input int n);
    m_owner = n;
    m_beats = 0;
    m_last  = n;
    m_sel   = (n == 2);
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner = 0;
      m_beats = 0;
      m_last  = 2;
      m_sel   = 1'b0;
      m_ov    = 1'b0;
      m_od    = 8'h00;
    end else begin
      automatic bit took = (m_owner != 0) && vof(m_owner) && (!m_ov || out_ready);
      automatic int other = 3 - m_owner;
      if (took) begin
        m_ov = 1'b1;
        m_od = dof(m_owner);
      end else if (m_ov && out_ready) begin
        m_ov = 1'b0;
      end
      if (m_owner == 0) begin
        if (in1_valid && in2_valid) give((m_last == 1) ? 2 : 1);
        else if (in1_valid)         give(1);
        else if (in2_valid)         give(2);
      end else if (!vof(m_owner)) begin
        if (vof(other)) give(other);
        else begin
          m_owner = 0;
          m_beats = 0;
        end
      end else if (took) begin
        if (m_beats + 1 >= BURST_MAX && vof(other)) give(other);
        else m_beats = (m_beats + 1 > BURST_MAX) ? BURST_MAX : m_beats + 1;
      end
    end
  end

  int         cyc = 0;
  logic [7:0] dlv[$];
  int         dlv_cyc[$];

  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      chk1("in1_ready", in1_ready, (m_owner == 1) && (!m_ov || out_ready));
      chk1("in2_ready", in2_ready, (m_owner == 2) && (!m_ov || out_ready));
      chk1("out_valid", out_valid, m_ov);
      chk8("out_data", out_data, m_od);
      chk1("select", select, m_sel);
      chk1("busy", busy, m_owner != 0);
      if (out_valid && out_ready) begin
        dlv.push_back(out_data);
        dlv_cyc.push_back(cyc);
      end
    end
  end

  // Stimulus control
  bit         rnd;
  bit         en1, en2;
  int         lim1, lim2, n1, n2;
  logic [7:0] base1, base2;
  logic       ordy;

  task automatic drive();
    if (rnd) begin
      in1_valid = ($urandom_range(0, 3) != 0);
      in2_valid = ($urandom_range(0, 3) != 0);
      in1_data  = 8'($urandom);
      in2_data  = 8'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
    end else begin
      in1_valid = en1 && (n1 < lim1);
      in2_valid = en2 && (n2 < lim2);
      in1_data  = base1 + 8'(n1);
      in2_data  = base2 + 8'(n2);
      out_ready = ordy;
    end
  endtask

  task automatic step();
    bit a1, a2;
    @(negedge clk);
    a1 = in1_valid && in1_ready;
    a2 = in2_valid && in2_ready;
    @(posedge clk);
    #1;
    if (a1) n1++;
    if (a2) n2++;
    drive();
  endtask

  task automatic quiesce();
    rnd = 0; en1 = 0; en2 = 0; n1 = 0; n2 = 0; ordy = 1'b1;
    drive();
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    dlv.delete();
    dlv_cyc.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    quiesce();
    repeat (2) @(posedge clk);
    release_rst();
  endtask

  task automatic chk_seq(input string name, input logic [7:0] exp[$]);
    chki({name, "_len"}, dlv.size(), exp.size());
    for (int i = 0; i < exp.size(); i++)
      chk8(name, (i < dlv.size()) ? dlv[i] : 8'hxx, exp[i]);
  endtask

  logic [7:0] exp_t2[$];

  initial begin
    base1 = 8'h00; base2 = 8'h00; lim1 = 0; lim2 = 0;
    quiesce();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk1("rst_out_valid", out_valid, 1'b0);
    chk8("rst_out_data", out_data, 8'h00);
    chk1("rst_select", select, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_in1_ready", in1_ready, 1'b0);
    chk1("rst_in2_ready", in2_ready, 1'b0);
    repeat (2) @(posedge clk);
    release_rst();

    // Single requester stream: IDLE bubble then one beat per cycle
    base1 = 8'h11; lim1 = 3; en1 = 1;
    drive();
    chk1("t1_idle_ready", in1_ready, 1'b0);
    step();
    chk1("t1_ov0", out_valid, 1'b1);
    chk8("t1_d0", out_data, 8'h11);
    chk1("t1_sel", select, 1'b0);
    step();
    chk8("t1_d1", out_data, 8'h12);
    step();
    chk8("t1_d2", out_data, 8'h13);
    repeat (3) step();
    chk_seq("t1_seq", '{8'h11, 8'h12, 8'h13});
    chk1("t1_idle_busy", busy, 1'b0);

    // Both continuously valid: bursts of BURST_MAX, no bubble at switches
    do_reset();
    base1 = 8'hA0; base2 = 8'hB0; lim1 = 8; lim2 = 8; en1 = 1; en2 = 1;
    drive();
    repeat (20) step();
    exp_t2 = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hB0, 8'hB1, 8'hB2, 8'hB3,
               8'hA4, 8'hA5, 8'hA6, 8'hA7, 8'hB4, 8'hB5, 8'hB6, 8'hB7};
    chk_seq("t2_seq", exp_t2);
    chki("t2_span", (dlv_cyc.size() == 16) ? dlv_cyc[15] - dlv_cyc[0] : -1, 15);

    // Tie-break: first tie after reset to in1, tie after an in1 grant to in2
    do_reset();
    base1 = 8'hC1; base2 = 8'hD1; lim1 = 1; lim2 = 1; en1 = 1; en2 = 1;
    drive();
    repeat (6) step();
    chk_seq("t3_tie_rst", '{8'hC1, 8'hD1});
    do_reset();
    base1 = 8'hE1; lim1 = 1; en1 = 1;
    drive();
    repeat (4) step();
    n1 = 0; n2 = 0; base1 = 8'hF1; base2 = 8'hF2; lim2 = 1; en2 = 1;
    drive();
    repeat (6) step();
    chk_seq("t3_tie_after1", '{8'hE1, 8'hF2, 8'hF1});

    // Backpressure in GRANT1 must freeze readies, data and the burst count
    do_reset();
    base1 = 8'h30; lim1 = 6; base2 = 8'h40; lim2 = 1; en1 = 1; en2 = 1;
    drive();
    step();
    ordy = 1'b0;
    step();
    for (int k = 0; k < 3; k++) begin
      #1;
      chk1("t4_ready_hold", in1_ready, 1'b0);
      chk1("t4_ov_hold", out_valid, 1'b1);
      chk8("t4_data_hold", out_data, 8'h31);
      step();
    end
    ordy = 1'b1;
    drive();
    repeat (12) step();
    chk_seq("t4_seq", '{8'h30, 8'h31, 8'h32, 8'h33, 8'h40, 8'h34, 8'h35});

    // in1 drops valid after two beats while in2 waits
    do_reset();
    base1 = 8'h50; lim1 = 2; base2 = 8'h60; lim2 = 2; en1 = 1; en2 = 1;
    drive();
    repeat (2) step();
    chk1("t5_sel_before", select, 1'b0);
    step();
    chk1("t5_sel_switch", select, 1'b1);
    chk1("t5_in2_ready", in2_ready, 1'b1);
    step();
    chk8("t5_first_in2", out_data, 8'h60);
    repeat (4) step();
    chk_seq("t5_seq", '{8'h50, 8'h51, 8'h60, 8'h61});

    // Asynchronous reset in the middle of an in2 burst
    do_reset();
    base2 = 8'h70; lim2 = 10; en2 = 1;
    drive();
    repeat (3) step();
    chk1("t6_ov_pre", out_valid, 1'b1);
    chk1("t6_sel_pre", select, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk1("t6_ov_async", out_valid, 1'b0);
    chk1("t6_busy_async", busy, 1'b0);
    chk1("t6_sel_async", select, 1'b0);
    chk1("t6_rdy_async", in2_ready, 1'b0);
    quiesce();
    @(posedge clk);
    release_rst();
    base1 = 8'h81; base2 = 8'h82; lim1 = 1; lim2 = 1; en1 = 1; en2 = 1;
    drive();
    repeat (6) step();
    chk_seq("t6_tie", '{8'h81, 8'h82});

    // Randomized traffic against the model
    do_reset();
    rnd = 1;
    drive();
    repeat (3000) step();
    quiesce();
    repeat (5) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
